// File: rtl/life_engine_if.sv
// life_engine_if: host/display-side bus of the Game-of-Life engine.
//   master : board control / display side (drives control, seed and read address)
//   slave  : life_engine
// Signals:
//   run, step, pause, clear      generation control
//   birth_mask, survive_mask     rule, bit n = neighbour count n
//   wr_en, wr_x, wr_y, wr_val    seed write into the front bank
//   rd_x, rd_y, rd_cell          display read port (rd_cell registered)
//   busy, gen_done, gen_count    status
interface life_engine_if #(
   parameter int XW    = 4,
   parameter int YW    = 4,
   parameter int GEN_W = 16
);
   logic             run;
   logic             step;
   logic             pause;
   logic             clear;
   logic [8:0]       birth_mask;
   logic [8:0]       survive_mask;
   logic             wr_en;
   logic [XW-1:0]    wr_x;
   logic [YW-1:0]    wr_y;
   logic             wr_val;
   logic [XW-1:0]    rd_x;
   logic [YW-1:0]    rd_y;
   logic             rd_cell;
   logic             busy;
   logic             gen_done;
   logic [GEN_W-1:0] gen_count;

   modport master (
      output run, step, pause, clear, birth_mask, survive_mask,
             wr_en, wr_x, wr_y, wr_val, rd_x, rd_y,
      input  rd_cell, busy, gen_done, gen_count
   );

   modport slave (
      input  run, step, pause, clear, birth_mask, survive_mask,
             wr_en, wr_x, wr_y, wr_val, rd_x, rd_y,
      output rd_cell, busy, gen_done, gen_count
   );
endinterface

// File: rtl/life_engine.sv
// life_engine: Game-of-Life generation engine with ping-pong field storage.
// Sweeps one cell per clock, reading the front bank and writing the back bank,
// then swaps the banks in a single SWAP cycle.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset (clears both banks and all status)
//   bus  life_engine_if.slave: control, rule masks, seed write, display read,
//        busy / gen_done / gen_count status
// The bus interface must be instantiated with XW/YW/GEN_W matching this module.
module life_engine #(
   parameter int FIELD_W = 16,
   parameter int FIELD_H = 16,
   parameter bit TORUS   = 1'b1,
   parameter int GEN_W   = 16,
   localparam int XW     = $clog2(FIELD_W),
   localparam int YW     = $clog2(FIELD_H)
) (
   input logic          clk,
   input logic          rst,
   life_engine_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_SWAP} state_e;

   localparam logic [XW-1:0] X_LAST = XW'(FIELD_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(FIELD_H - 1);

   state_e           state_q, state_d;
   logic [XW-1:0]    x_q, x_d;
   logic [YW-1:0]    y_q, y_d;
   logic             fsel_q, fsel_d;
   logic [8:0]       birth_q, birth_d;
   logic [8:0]       surv_q, surv_d;
   logic [GEN_W-1:0] gen_q, gen_d;
   logic             done_q, done_d;
   logic             rd_q;

   // bank_q[fsel_q] is the front (displayed) field, the other one is written
   logic [1:0][FIELD_H-1:0][FIELD_W-1:0] bank_q;
   logic [FIELD_H-1:0][FIELD_W-1:0]      front;

   logic             clr_front, seed_we, cell_we, next_val;
   logic             wr_x_ok, wr_y_ok, rd_x_ok, rd_y_ok;
   logic [2:0][XW-1:0] nx;
   logic [2:0][YW-1:0] ny;
   logic [2:0]       nx_ok, ny_ok;
   logic [3:0]       nbr;

   assign front = bank_q[fsel_q];

   // Coordinate range checks only exist when the field does not fill the
   // full address space of its coordinate width.
   if ((1 << XW) == FIELD_W) begin : g_x_full
      assign wr_x_ok = 1'b1;
      assign rd_x_ok = 1'b1;
   end else begin : g_x_part
      assign wr_x_ok = (bus.wr_x <= X_LAST);
      assign rd_x_ok = (bus.rd_x <= X_LAST);
   end

   if ((1 << YW) == FIELD_H) begin : g_y_full
      assign wr_y_ok = 1'b1;
      assign rd_y_ok = 1'b1;
   end else begin : g_y_part
      assign wr_y_ok = (bus.wr_y <= Y_LAST);
      assign rd_y_ok = (bus.rd_y <= Y_LAST);
   end

   // Neighbour coordinates: index 0 = -1, 1 = centre, 2 = +1. Wrapped
   // coordinates are always generated; the _ok bits kill them at a dead edge.
   always_comb begin
      nx[0] = (x_q == '0)     ? X_LAST : x_q - 1'b1;
      nx[1] = x_q;
      nx[2] = (x_q == X_LAST) ? '0     : x_q + 1'b1;
      ny[0] = (y_q == '0)     ? Y_LAST : y_q - 1'b1;
      ny[1] = y_q;
      ny[2] = (y_q == Y_LAST) ? '0     : y_q + 1'b1;
      nx_ok = {TORUS | (x_q != X_LAST), 1'b1, TORUS | (x_q != '0)};
      ny_ok = {TORUS | (y_q != Y_LAST), 1'b1, TORUS | (y_q != '0)};
      nbr   = '0;
      for (int j = 0; j < 3; j++) begin
         for (int i = 0; i < 3; i++) begin
            if (!(i == 1 && j == 1)) begin
               nbr = nbr + {3'b000, front[ny[j]][nx[i]] & nx_ok[i] & ny_ok[j]};
            end
         end
      end
   end

   assign next_val = front[y_q][x_q] ? surv_q[nbr] : birth_q[nbr];

   // Next-state logic. In IDLE clear beats seed write beats start; a held
   // run simply starts on the first free cycle.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      fsel_d    = fsel_q;
      birth_d   = birth_q;
      surv_d    = surv_q;
      gen_d     = gen_q;
      done_d    = 1'b0;
      clr_front = 1'b0;
      seed_we   = 1'b0;
      cell_we   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.clear) begin
               clr_front = 1'b1;
            end else if (bus.wr_en) begin
               seed_we = wr_x_ok & wr_y_ok;
            end else if ((bus.run & ~bus.pause) | bus.step) begin
               state_d = S_SWEEP;
               x_d     = '0;
               y_d     = '0;
               birth_d = bus.birth_mask;
               surv_d  = bus.survive_mask;
            end
         end
         S_SWEEP: begin
            if (!bus.pause) begin
               cell_we = 1'b1;
               if (x_q == X_LAST) begin
                  x_d = '0;
                  if (y_q == Y_LAST) begin
                     y_d     = '0;
                     state_d = S_SWAP;
                  end else begin
                     y_d = y_q + 1'b1;
                  end
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
         S_SWAP: begin
            fsel_d  = ~fsel_q;
            gen_d   = gen_q + 1'b1;
            done_d  = 1'b1;
            x_d     = '0;
            y_d     = '0;
            state_d = (bus.run & ~bus.pause) ? S_SWEEP : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         fsel_q  <= 1'b0;
         birth_q <= '0;
         surv_q  <= '0;
         gen_q   <= '0;
         done_q  <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         fsel_q  <= fsel_d;
         birth_q <= birth_d;
         surv_q  <= surv_d;
         gen_q   <= gen_d;
         done_q  <= done_d;
         // Front bank only changes on a swap, so a sweep in progress still
         // shows the previous generation.
         rd_q    <= (rd_x_ok & rd_y_ok) ? front[bus.rd_y][bus.rd_x] : 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q <= '0;
      end else if (clr_front) begin
         bank_q[fsel_q] <= '0;
      end else if (seed_we) begin
         bank_q[fsel_q][bus.wr_y][bus.wr_x] <= bus.wr_val;
      end else if (cell_we) begin
         bank_q[~fsel_q][y_q][x_q] <= next_val;
      end
   end

   assign bus.rd_cell   = rd_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.gen_done  = done_q;
   assign bus.gen_count = gen_q;

endmodule

// File: doc/life_engine.md
Name: life_engine

Overview:
- Parametrised Game-of-Life generation engine with its own field storage.
- Holds two field banks as a ping-pong pair and sweeps one cell per clock: reads the front bank, writes the back bank, then swaps.
- Supports a run-time rule selected by birth/survive masks, torus or dead-edge boundary, free-run/single-step/pause control, host seeding and a display read port.
- Sits between the board control logic (buttons, seed loader) and the video/display path.

Parameters:
- FIELD_W, 16, field width in cells (>=3).
- FIELD_H, 16, field height in cells (>=3).
- TORUS, 1, 1 = edges wrap; 0 = out-of-field neighbours count as dead.
- GEN_W, 16, width of the generation counter.
- Derived: XW = $clog2(FIELD_W), YW = $clog2(FIELD_H).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- run  in  1  level; free-run generations while high
- step  in  1  one-cycle pulse; compute exactly one generation when idle
- pause  in  1  level; freezes an ongoing sweep
- clear  in  1  pulse; zero the front bank (idle only)
- birth_mask  in  9  bit n = dead cell with n live neighbours is born
- survive_mask  in  9  bit n = live cell with n live neighbours survives
- wr_en  in  1  seed write strobe into front bank
- wr_x  in  XW  seed x
- wr_y  in  YW  seed y
- wr_val  in  1  seed value
- rd_x  in  XW  display read x
- rd_y  in  YW  display read y
- rd_cell  out  1  registered front-bank cell at (rd_x, rd_y)
- busy  out  1  high in SWEEP and SWAP
- gen_done  out  1  one-cycle pulse per completed generation
- gen_count  out  GEN_W  completed generations, wraps modulo 2^GEN_W

Behaviour:
- Reset (async, rst=1):
  - Both banks cleared; front_sel=0; state IDLE; x=y=0.
  - rd_cell=0, busy=0, gen_done=0, gen_count=0.
- State IDLE:
  - Starts a sweep when (run & ~pause) | step is sampled. Next state SWEEP at x=y=0.
  - birth_mask and survive_mask are latched on that edge; mask changes mid-sweep have no effect.
  - Priority when several inputs arrive in the same cycle: clear > wr_en > start.
  - clear or wr_en in the same cycle as a start: the start is deferred, not lost when run is held. A step is dropped in that case.
- State SWEEP:
  - Each cycle (unless pause=1): n = live count of the 8 neighbours of (x,y) in the front bank, 0..8, 4-bit.
  - back[x,y] <= front[x,y] ? survive_l[n] : birth_l[n].
  - x increments fastest; at x=FIELD_W-1, x<=0 and y++.
  - pause=1 holds x, y and write-enable; resumes exactly where it stopped.
  - step, clear and wr_en are ignored during SWEEP and SWAP.
- Boundary:
  - TORUS=1: neighbour coordinates taken modulo FIELD_W / FIELD_H.
  - TORUS=0: neighbours with coordinates -1 or W/H contribute 0.
- Final cell (x=W-1, y=H-1) written: state goes to SWAP.
- State SWAP (one cycle):
  - front_sel toggles, gen_count increments and gen_done=1, all on the exit edge.
  - Next state is SWEEP at (0,0) if run & ~pause, else IDLE. A step-started sweep returns to IDLE unless run is high.
- Latency:
  - Start sampled at edge E0 gives W*H SWEEP cycles; gen_done is high in the cycle after edge E0+W*H+1.
  - Free-run period is W*H+1 cycles per generation.
- Seeding:
  - wr_en in IDLE writes front[wr_x,wr_y] <= wr_val.
  - Out-of-range coordinates (>= FIELD_W/FIELD_H) are ignored.
- Read port:
  - rd_cell registered with 1-cycle latency; returns the front bank as of the sampling edge.
  - Out-of-range coordinates return 0.
  - Reading during a sweep returns the previous generation, so the display never shows a torn frame.
- Reset mid-sweep aborts immediately: banks cleared, gen_count=0, no gen_done pulse.
- Runt fields (W or H < 3) are not supported.

Test Plan:
- 5x5, TORUS=0, B=9'h008, S=9'h00C; seed (1,2),(2,2),(3,2); step -> gen_done 27 cycles after step. Front = (2,1),(2,2),(2,3) only; gen_count=1; second step restores the horizontal line.
- 8x8, TORUS=1, Conway rule; glider at (1,0),(2,1),(0,2),(1,2),(2,2); run for 32 generations -> pattern identical to seed; gen_count=32; consecutive gen_done pulses 65 cycles apart.
- Same glider with TORUS=0 -> becomes a 2x2 block at the corner and is stable; no live cell ever outside the field.
- Pause held 10 cycles starting at cell (3,1) of a blinker sweep -> gen_done delayed by exactly 10 cycles; result identical to the unpaused run. wr_en, step and clear during the pause have no effect.
- Rule B=9'h004, S=0 (Seeds); two live cells (2,2),(3,2) on 6x6 -> next generation live exactly at (2,1),(3,1),(2,3),(3,3). Flipping the masks mid-sweep does not change this result.
- Async rst asserted mid-sweep between edges -> all outputs 0 immediately; rd_cell=0 at all addresses afterwards; gen_count=0; a subsequent step on the empty field gives gen_count=1 with the field still empty.
